// File: rtl/clyde_pkg.sv
// Shared Clyde-128 L-box constants plus the rotate and forward L-box helpers
// used by the inverse datapath, its benches and its assertions.
package clyde_pkg;

    localparam int WORD_W = 32;

    // Forward L-box rotation amounts (all rotate-right)
    localparam int FWD_R0 = 12;
    localparam int FWD_R1 = 3;
    localparam int FWD_R2 = 17;
    localparam int FWD_R3 = 31;
    localparam int FWD_R4 = 26;
    localparam int FWD_R5 = 25;
    localparam int FWD_R6 = 15;

    // Inverse L-box rotation amounts (all rotate-right)
    localparam int INV_R0 = 25;
    localparam int INV_R1 = 31;
    localparam int INV_R2 = 20;
    localparam int INV_R3 = 26;
    localparam int INV_R4 = 17;
    localparam int INV_R5 = 16;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v,
                                               input int unsigned      k);
        return (v >> k) | (v << (WORD_W - k));
    endfunction

    // Forward map F; returns {a, b}
    function automatic logic [2*WORD_W-1:0] lbox_fwd(input logic [WORD_W-1:0] x,
                                                     input logic [WORD_W-1:0] y);
        logic [WORD_W-1:0] a, b, c, d;
        a = x ^ rotr(x, FWD_R0);
        b = y ^ rotr(y, FWD_R0);
        a = a ^ rotr(a, FWD_R1);
        b = b ^ rotr(b, FWD_R1);
        a = a ^ rotr(x, FWD_R2);
        b = b ^ rotr(y, FWD_R2);
        c = a ^ rotr(a, FWD_R3);
        d = b ^ rotr(b, FWD_R3);
        a = a ^ rotr(d, FWD_R4) ^ rotr(c, FWD_R6);
        b = b ^ rotr(c, FWD_R5) ^ rotr(d, FWD_R6);
        return {a, b};
    endfunction

endpackage

// File: rtl/lbox_inv_comb.sv
// Purely combinational inverse Clyde-128 L-box G; XOR/rotate network only,
// shared with the unmasked reference core.
module lbox_inv_comb
    import clyde_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    output logic [WORD_W-1:0] a,
    output logic [WORD_W-1:0] b
);

    logic [WORD_W-1:0] ta, tb, tc, td;
    logic [WORD_W-1:0] ua, ub, uc, ud;
    logic [WORD_W-1:0] va, vb;

    assign ta = x ^ rotr(x, INV_R0);
    assign tb = y ^ rotr(y, INV_R0);
    assign tc = x ^ rotr(ta, INV_R1) ^ rotr(ta, INV_R2);
    assign td = y ^ rotr(tb, INV_R1) ^ rotr(tb, INV_R2);

    // The two halves cross-couple here, undoing the d/c mixing of F
    assign ua = tc ^ rotr(tc, INV_R1);
    assign ub = td ^ rotr(td, INV_R1);
    assign uc = tc ^ rotr(ub, INV_R3);
    assign ud = td ^ rotr(ua, FWD_R5);
    assign va = ua ^ rotr(uc, INV_R4);
    assign vb = ub ^ rotr(ud, INV_R4);

    assign a = rotr(va, INV_R5);
    assign b = rotr(vb, INV_R5);

endmodule

// File: rtl/clyde_lbox_inv_stream.sv
// Elastic streaming inverse L-box with share/pair frame tagging.
// Define CLYDE_LBOX_INV_OUTREG_EN to add a second register stage after G.
module clyde_lbox_inv_stream
    import clyde_pkg::*;
#(
    parameter int NSHARES = 2,
    parameter int SHW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_x,
    input  logic [WORD_W-1:0] in_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_x,
    output logic [WORD_W-1:0] out_y,
    output logic [SHW-1:0]    out_share,
    output logic              out_pair,
    output logic              out_last
);

    localparam logic [SHW-1:0] LAST_SHARE = SHW'(NSHARES - 1);

    logic [WORD_W-1:0] g_x, g_y;
    logic              s1_valid;
    logic [WORD_W-1:0] s1_x, s1_y;
    logic [SHW-1:0]    share_q;
    logic              pair_q;

    lbox_inv_comb u_lbox_inv (
        .x (in_x),
        .y (in_y),
        .a (g_x),
        .b (g_y)
    );

`ifdef CLYDE_LBOX_INV_OUTREG_EN
    logic              s2_valid;
    logic              s2_ready;
    logic [WORD_W-1:0] s2_x, s2_y;

    assign s2_ready = !s2_valid || out_ready;
    assign in_ready = !flush && (!s1_valid || s2_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_x     <= g_x;
            s1_y     <= g_y;
        end else if (s2_ready) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_x     <= '0;
            s2_y     <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_x <= s1_x;
                s2_y <= s1_y;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_x     = s2_x;
    assign out_y     = s2_y;
`else
    assign in_ready = !flush && (!s1_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_x     <= g_x;
            s1_y     <= g_y;
        end else if (out_ready) begin
            s1_valid <= 1'b0;
        end
    end

    assign out_valid = s1_valid;
    assign out_x     = s1_x;
    assign out_y     = s1_y;
`endif

    // Frame position of the pair on the output; a flushed transfer never counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            share_q <= '0;
            pair_q  <= 1'b0;
        end else if (flush) begin
            share_q <= '0;
            pair_q  <= 1'b0;
        end else if (out_valid && out_ready) begin
            pair_q <= !pair_q;
            if (pair_q) begin
                share_q <= (share_q == LAST_SHARE) ? '0 : share_q + SHW'(1);
            end
        end
    end

    assign out_share = share_q;
    assign out_pair  = pair_q;
    assign out_last  = out_valid && (share_q == LAST_SHARE) && pair_q;

endmodule

// File: tb/tb_clyde_lbox_inv_stream.sv
// Scoreboard bench for clyde_lbox_inv_stream: inputs are queued at handshake,
// outputs are checked by round trip through F and against a frame position model.
module tb_clyde_lbox_inv_stream;
    import clyde_pkg::*;

    localparam int NSHARES = 2;
    localparam int SHW     = 3;
`ifdef CLYDE_LBOX_INV_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [31:0]    x;
        logic [31:0]    y;
        logic [SHW-1:0] share;
        logic           pair;
        logic           last;
    } obs_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [31:0]    in_x, in_y;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_x, out_y;
    logic [SHW-1:0] out_share;
    logic           out_pair;
    logic           out_last;

    logic [63:0]    exp_q[$];
    obs_t           out_log[$];
    int             n_checks = 0;
    int             n_pass   = 0;
    int             exp_idx  = 0;
    bit             rnd_ready = 1'b0;

    logic [63:0]    mon_exp;
    obs_t           mon_obs;
    logic [SHW+1:0] exp_tag;

    clyde_lbox_inv_stream #(.NSHARES(NSHARES), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_share (out_share),
        .out_pair  (out_pair),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: mid-cycle view of the handshakes that complete at the next rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_idx = 0;
        end else if (flush) begin
            checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
            exp_q.delete();
            exp_idx = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("round_trip", lbox_fwd(out_x, out_y), mon_exp);
                    exp_tag = {SHW'(exp_idx / 2), (exp_idx % 2) == 1, exp_idx == 2*NSHARES-1};
                    checkOutput("frame_tag", 64'({out_share, out_pair, out_last}), 64'(exp_tag));
                    exp_idx = (exp_idx + 1) % (2*NSHARES);
                end
                mon_obs.x     = out_x;
                mon_obs.y     = out_y;
                mon_obs.share = out_share;
                mon_obs.pair  = out_pair;
                mon_obs.last  = out_last;
                out_log.push_back(mon_obs);
            end
            if (in_valid && in_ready) exp_q.push_back({in_x, in_y});
        end
    end

    always @(posedge clk) begin
        if (rnd_ready) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Offers one pair and returns one step after the edge that accepted it
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) checkOutput("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic idleCycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic waitLog(input int n);
        int i = 0;
        while (out_log.size() < n && i < 1000) begin
            @(posedge clk);
            #1;
            i++;
        end
        checkOutput("log_timeout", 64'(out_log.size() >= n), 64'd1);
    endtask

    task automatic drain();
        int i = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && i < 1000) begin
            @(posedge clk);
            #1;
            i++;
        end
        checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    logic [31:0] bp_x[4];
    logic [31:0] bp_y[4];
    logic [31:0] ux, uy, vx, vy;
    int          idx;
    bit          acc, stall_seen;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset values
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_x",     64'(out_x),     64'd0);
        checkOutput("rst_out_y",     64'(out_y),     64'd0);
        checkOutput("rst_out_share", 64'(out_share), 64'd0);
        checkOutput("rst_out_pair",  64'(out_pair),  64'd0);
        checkOutput("rst_out_last",  64'(out_last),  64'd0);
        checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;

        // Zero pair and latency
        applyStimulus(32'h0, 32'h0);
        in_valid = 1'b0;
        repeat (LAT-1) @(posedge clk);
        @(negedge clk);
        checkOutput("zero_latency_valid", 64'(out_valid), 64'd1);
        checkOutput("zero_value", {out_x, out_y}, 64'd0);
        @(posedge clk);
        #1;
        drain();

        // Linearity
        ux = 32'hDEADBEEF; uy = 32'h01234567;
        vx = 32'h89ABCDEF; vy = 32'hCAFEBABE;
        out_log.delete();
        applyStimulus(ux, uy);
        applyStimulus(vx, vy);
        applyStimulus(ux ^ vx, uy ^ vy);
        in_valid = 1'b0;
        waitLog(3);
        if (out_log.size() >= 3)
            checkOutput("linearity", {out_log[2].x, out_log[2].y},
                        {out_log[0].x ^ out_log[1].x, out_log[0].y ^ out_log[1].y});
        drain();

        // Framing over 8 back-to-back pairs from a fresh counter
        flush = 1'b1;
        idleCycle();
        flush = 1'b0;
        out_log.delete();
        for (int i = 0; i < 8; i++) applyStimulus($urandom, $urandom);
        in_valid = 1'b0;
        waitLog(8);
        for (int i = 0; i < 8 && i < out_log.size(); i++) begin
            checkOutput("frame_seq",
                        64'({out_log[i].share, out_log[i].pair, out_log[i].last}),
                        64'({SHW'((i / 2) % 2), (i % 2) == 1, (i % 4) == 3}));
        end
        drain();

        // Backpressure: three pairs against a stalled output for five cycles
        for (int i = 0; i < 4; i++) begin
            bp_x[i] = $urandom;
            bp_y[i] = $urandom;
        end
        out_ready  = 1'b0;
        out_log.delete();
        idx        = 0;
        stall_seen = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc == 5) out_ready = 1'b1;
            in_valid = (idx < 3);
            in_x     = bp_x[idx];
            in_y     = bp_y[idx];
            @(negedge clk);
            acc = in_valid && in_ready;
            if (!in_ready && !out_ready) stall_seen = 1'b1;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        checkOutput("bp_stall_seen", 64'(stall_seen), 64'd1);
        checkOutput("bp_accepted", 64'(idx), 64'd3);
        waitLog(3);
        repeat (4) idleCycle();
        checkOutput("bp_count", 64'(out_log.size()), 64'd3);
        for (int i = 0; i < 3 && i < out_log.size(); i++)
            checkOutput("bp_order", lbox_fwd(out_log[i].x, out_log[i].y), {bp_x[i], bp_y[i]});
        drain();

        // Flush after 2 of 4 pairs, with the counter off zero beforehand
        applyStimulus($urandom, $urandom);
        drain();
        applyStimulus($urandom, $urandom);
        applyStimulus($urandom, $urandom);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_x     = $urandom;
        in_y     = $urandom;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        out_log.delete();
        applyStimulus($urandom, $urandom);
        applyStimulus($urandom, $urandom);
        in_valid = 1'b0;
        waitLog(1);
        if (out_log.size() >= 1)
            checkOutput("flush_first_tag", 64'({out_log[0].share, out_log[0].pair}), 64'd0);
        drain();

        // Asynchronous reset while a pair is held at the output
        out_ready = 1'b0;
        applyStimulus(32'hA5A5F00F, 32'h3C3C1234);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pre_reset_valid", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("arst_out_xy",    {out_x, out_y}, 64'd0);
        checkOutput("arst_out_tag",   64'({out_share, out_pair, out_last}), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;

        // Unit vectors then random pairs under random bubbles and backpressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 32; i++) applyStimulus(32'd1 << i, 32'd0);
        for (int i = 0; i < 32; i++) applyStimulus(32'd0, 32'd1 << i);
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) == 0) idleCycle();
            applyStimulus($urandom, $urandom);
        end
        in_valid  = 1'b0;
        rnd_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk);
        #1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
